// File: rtl/ddr_request_responder_if.sv
// Request/response bundle between the pixel-engine requesters, the responder and the DDR core.
// The slave modport is the responder's view; master is the requester/memory side.
interface ddr_request_responder_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic                  read;
  logic [ADDR_WIDTH-1:0] readAddress;
  logic                  readAcknowledge;
  logic [DATA_WIDTH-1:0] readData;
  logic                  write;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  writeAcknowledge;
  logic                  mem_cmd_valid;
  logic                  mem_cmd_ready;
  logic                  mem_cmd_write;
  logic [ADDR_WIDTH-1:0] mem_cmd_addr;
  logic [DATA_WIDTH-1:0] mem_cmd_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  busy;

  modport slave (
    input  read, readAddress, write, writeAddress, writeData,
           mem_cmd_ready, mem_rsp_valid, mem_rsp_data,
    output readAcknowledge, readData, writeAcknowledge,
           mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, busy
  );

  modport master (
    output read, readAddress, write, writeAddress, writeData,
           mem_cmd_ready, mem_rsp_valid, mem_rsp_data,
    input  readAcknowledge, readData, writeAcknowledge,
           mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, busy
  );
endinterface

// File: rtl/ddr_request_responder.sv
// Round-robin read/write responder: one memory command in flight, four-phase acks to the requester.
module ddr_request_responder #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  ddr_request_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  state_t                state;
  logic                  last_grant;  // 1 = write granted last
  logic                  cmd_valid;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rack, wack, busy_q;

  logic read_elig, write_elig, grant_write;

  // A side whose ack is still high has not finished its handshake and is not a new request.
  assign read_elig   = bus.read  && !rack;
  assign write_elig  = bus.write && !wack;
  assign grant_write = write_elig && (!read_elig || !last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmd_valid  <= 1'b0;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rdata      <= '0;
      rack       <= 1'b0;
      wack       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (!bus.read)  rack <= 1'b0;
      if (!bus.write) wack <= 1'b0;

      case (state)
        IDLE: begin
          if (read_elig || write_elig) begin
            cmd_write  <= grant_write;
            cmd_addr   <= grant_write ? bus.writeAddress : bus.readAddress;
            if (grant_write) cmd_wdata <= bus.writeData;
            last_grant <= grant_write;
            cmd_valid  <= 1'b1;
            busy_q     <= 1'b1;
            state      <= CMD;
          end
        end
        CMD: begin
          if (bus.mem_cmd_ready) begin
            cmd_valid <= 1'b0;
            if (cmd_write) begin
              wack   <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              state  <= RSP;
            end
          end
        end
        RSP: begin
          if (bus.mem_rsp_valid) begin
            rdata  <= bus.mem_rsp_data;
            rack   <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_cmd_valid    = cmd_valid;
  assign bus.mem_cmd_write    = cmd_write;
  assign bus.mem_cmd_addr     = cmd_addr;
  assign bus.mem_cmd_wdata    = cmd_wdata;
  assign bus.readData         = rdata;
  assign bus.readAcknowledge  = rack;
  assign bus.writeAcknowledge = wack;
  assign bus.busy             = busy_q;
endmodule

// File: tb/tb_ddr_request_responder.sv
// Directed and randomized checks of ddr_request_responder, acting as both requester and memory.
module tb_ddr_request_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic m_last;  // model: 1 = write was granted last

  always #5 clk = ~clk;

  ddr_request_responder_if #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) bus ();

  ddr_request_responder #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.read = 0; bus.readAddress = '0; bus.write = 0; bus.writeAddress = '0;
    bus.writeData = '0; bus.mem_cmd_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); step(); rst = 0;
    m_last = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {bus.readAcknowledge, bus.readData, bus.writeAcknowledge, bus.mem_cmd_valid,
              bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_cmd_wdata, bus.busy}, 64'd0);
  endtask

  // Memory agent: waits for a command, holds ready low rdly cycles, responds to reads after sdly.
  task automatic serve(input int rdly, input int sdly, input logic [15:0] rsp,
                       output logic op, output logic [23:0] a, output logic [15:0] d);
    int i = 0;
    while (!bus.mem_cmd_valid && i < 30) begin step(); i++; end
    chk("cmd_valid", bus.mem_cmd_valid, 1'b1);
    op = bus.mem_cmd_write; a = bus.mem_cmd_addr; d = bus.mem_cmd_wdata;
    for (int k = 0; k < rdly; k++) begin
      step();
      chk("cmd_hold", {bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_cmd_wdata},
          {1'b1, op, a, d});
      chk("ack_before_accept", op ? bus.writeAcknowledge : bus.readAcknowledge, 1'b0);
    end
    bus.mem_cmd_ready = 1; step(); bus.mem_cmd_ready = 0;
    chk("valid_drop", bus.mem_cmd_valid, 1'b0);
    if (op) begin
      chk("wack", bus.writeAcknowledge, 1'b1);
    end else begin
      for (int k = 0; k < sdly; k++) begin
        chk("rack_early", {bus.readAcknowledge, bus.busy}, 2'b01);
        step();
      end
      bus.mem_rsp_valid = 1; bus.mem_rsp_data = rsp; step(); bus.mem_rsp_valid = 0;
      chk("rack", bus.readAcknowledge, 1'b1);
      chk("rdata", bus.readData, rsp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        op, exp_op, pr, pw;
    logic [23:0] a, ra, wa;
    logic [15:0] d, wd, rsp;
    int          kind;

    idle_inputs();
    #2;
    chk_all_zero("reset_async");
    do_reset();
    chk_all_zero("reset_state");

    // single write with ready tied high
    bus.mem_cmd_ready = 1;
    bus.write = 1; bus.writeAddress = 24'h001234; bus.writeData = 16'hBEEF;
    step();
    chk("wr_cmd", {bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_cmd_wdata,
                   bus.writeAcknowledge}, {1'b1, 1'b1, 24'h001234, 16'hBEEF, 1'b0});
    step();
    chk("wr_ack_edge2", {bus.writeAcknowledge, bus.mem_cmd_valid, bus.busy}, 3'b100);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wr_ack_held", {bus.writeAcknowledge, bus.mem_cmd_valid}, 2'b10);
    end
    bus.write = 0; step();
    chk("wr_ack_clear", bus.writeAcknowledge, 1'b0);
    bus.mem_cmd_ready = 0;

    // single read, response three cycles after the command
    bus.read = 1; bus.readAddress = 24'h000040; step();
    chk("rd_cmd", {bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_addr}, {1'b1, 1'b0, 24'h000040});
    bus.mem_cmd_ready = 1; step(); bus.mem_cmd_ready = 0;
    chk("rd_accept", {bus.mem_cmd_valid, bus.busy, bus.readAcknowledge}, 3'b010);
    step(); step();
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 16'hA5A5; step(); bus.mem_rsp_valid = 0;
    chk("rd_ack_data", {bus.readAcknowledge, bus.readData}, {1'b1, 16'hA5A5});
    bus.read = 0; step();
    chk("rd_ack_clear", {bus.readAcknowledge, bus.readData}, {1'b0, 16'hA5A5});

    // ties from reset: read, write, read, write
    do_reset();
    for (int r = 0; r < 2; r++) begin
      bus.read = 1; bus.readAddress = 24'h0A0A00 + 24'(r);
      bus.write = 1; bus.writeAddress = 24'h0B0B00 + 24'(r); bus.writeData = 16'h7000 + 16'(r);
      serve(0, 0, 16'h1200 + 16'(r), op, a, d);
      chk("tie_first_is_read", {op, a}, {1'b0, 24'h0A0A00 + 24'(r)});
      serve(0, 0, 16'h0, op, a, d);
      chk("tie_second_is_write", {op, a, d}, {1'b1, 24'h0B0B00 + 24'(r), 16'h7000 + 16'(r)});
      bus.read = 0; bus.write = 0; step();
      chk("tie_acks_clear", {bus.readAcknowledge, bus.writeAcknowledge}, 2'b00);
    end

    // ready held low for 5 cycles on a write
    bus.write = 1; bus.writeAddress = 24'hC0FFEE; bus.writeData = 16'h5A5A;
    serve(5, 0, 16'h0, op, a, d);
    chk("stall_fields", {op, a, d}, {1'b1, 24'hC0FFEE, 16'h5A5A});
    bus.write = 0; step();

    // read held high across its ack: only one command until the handshake completes
    bus.read = 1; bus.readAddress = 24'h000777;
    serve(0, 1, 16'h3C3C, op, a, d);
    chk("hold_op", {op, a}, {1'b0, 24'h000777});
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_no_reissue", {bus.mem_cmd_valid, bus.readAcknowledge}, 2'b01);
    end
    bus.read = 0; step();
    chk("hold_ack_clear", bus.readAcknowledge, 1'b0);
    bus.read = 1; bus.readAddress = 24'h000778;
    serve(0, 0, 16'h4D4D, op, a, d);
    chk("hold_reissue", {op, a}, {1'b0, 24'h000778});
    bus.read = 0; step();

    // reset while waiting for a read response; late response must be ignored
    do_reset();
    bus.read = 1; bus.readAddress = 24'h123456; step();
    bus.mem_cmd_ready = 1; step(); bus.mem_cmd_ready = 0;
    chk("rsp_state_busy", bus.busy, 1'b1);
    rst = 1; #1;
    chk_all_zero("reset_mid_rsp");
    bus.read = 0; step(); rst = 0;
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 16'h1111; step(); bus.mem_rsp_valid = 0;
    chk_all_zero("late_rsp_ignored");
    m_last = 1'b1;

    // randomized traffic against the transaction-level model
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      ra = 24'($urandom); wa = 24'($urandom); wd = 16'($urandom);
      pr = (kind != 1); pw = (kind != 0);
      bus.read = pr; bus.readAddress = ra;
      bus.write = pw; bus.writeAddress = wa; bus.writeData = wd;
      while (pr || pw) begin
        exp_op = (pr && pw) ? ~m_last : pw;
        m_last = exp_op;
        rsp = 16'($urandom);
        serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rsp, op, a, d);
        chk("rnd_op", op, exp_op);
        chk("rnd_addr", a, exp_op ? wa : ra);
        if (exp_op) begin
          chk("rnd_wdata", d, wd);
          pw = 0;
        end else begin
          pr = 0;
        end
      end
      bus.read = 0; bus.write = 0; step();
      chk("rnd_acks_clear", {bus.readAcknowledge, bus.writeAcknowledge, bus.busy}, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
